// File: rtl/qe_sim_generator_multi.sv
// Quadrature-encoder stimulus generator.
// Produces A/B Gray-code edges and an index pulse at a programmable edge
// rate, forward or reverse, either continuously or for a fixed burst of
// edges, and keeps a wrapping signed position count alongside.
//
//   state  | meaning
//   IDLE   | waiting for start with enable high
//   LOAD   | latch period/mode/burst length, arm edge timer
//   WAIT   | timer running, no edge visible this cycle
//   STEP   | an edge became visible this cycle; timer keeps running
//   DONE   | one-cycle burst completion pulse
//
// The edge registers update on the cycle the timer reaches 1 (in WAIT or
// STEP), so each edge shows up in the cycle the FSM enters STEP. The
// timer keeps counting through STEP, which keeps the edge spacing at
// exactly P cycles. At P=1 the FSM therefore stays in STEP.
module qe_sim_generator_multi #(
    parameter int TIMER_WIDTH = 16,
    parameter int COUNT_WIDTH = 16,
    parameter int REV_WIDTH   = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   start,
    input  logic                   mode,
    input  logic                   direction,
    input  logic [TIMER_WIDTH-1:0] phase_period,
    input  logic [COUNT_WIDTH-1:0] burst_count,
    input  logic [REV_WIDTH-1:0]   counts_per_rev,
    input  logic                   clear_position,
    output logic                   QE_A,
    output logic                   QE_B,
    output logic                   QE_I,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] position
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_STEP, S_DONE} state_t;

    state_t                 state, state_nxt;
    logic [TIMER_WIDTH-1:0] timer;
    logic [TIMER_WIDTH-1:0] period;
    logic [TIMER_WIDTH-1:0] period_in;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   mode_l;
    logic [1:0]             phase;
    logic [1:0]             phase_nxt;
    logic [REV_WIDTH-1:0]   rev_cnt;
    logic [REV_WIDTH-1:0]   rev_nxt;
    logic                   burst_end;
    logic                   fire;

    // Edge-fire decision, next phase and next index-counter value
    always_comb begin
        period_in = (phase_period == '0) ? TIMER_WIDTH'(1) : phase_period;
        burst_end = mode_l && (remaining == '0);
        fire      = enable && ((state == S_WAIT) || (state == S_STEP))
                    && (timer == TIMER_WIDTH'(1)) && !burst_end;
        phase_nxt = direction ? (phase - 2'd1) : (phase + 2'd1);
        rev_nxt   = '0;
        if (counts_per_rev != '0) begin
            if (!direction)
                rev_nxt = (rev_cnt >= counts_per_rev - 1'b1) ? '0 : rev_cnt + 1'b1;
            else
                rev_nxt = ((rev_cnt == '0) || (rev_cnt >= counts_per_rev))
                          ? counts_per_rev - 1'b1 : rev_cnt - 1'b1;
        end
    end

    // Next-state logic; dropping enable aborts from any state
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) state_nxt = S_LOAD;
                S_LOAD: state_nxt = (mode && (burst_count == '0)) ? S_DONE : S_WAIT;
                S_WAIT: if (fire) state_nxt = S_STEP;
                S_STEP: begin
                    if (burst_end)  state_nxt = S_DONE;
                    else if (fire)  state_nxt = S_STEP;
                    else            state_nxt = S_WAIT;
                end
                S_DONE: state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Run parameters, edge timer and burst remaining count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer     <= '0;
            period    <= '0;
            remaining <= '0;
            mode_l    <= 1'b0;
        end else if (state == S_LOAD) begin
            timer     <= period_in;
            period    <= period_in;
            remaining <= burst_count;
            mode_l    <= mode;
        end else if (fire) begin
            timer     <= period;
            remaining <= remaining - 1'b1;
        end else if (((state == S_WAIT) || (state == S_STEP)) && (timer != '0)) begin
            timer     <= timer - 1'b1;
        end
    end

    // Quadrature phase, index counter and registered A/B/I outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase   <= 2'd0;
            rev_cnt <= '0;
            QE_A    <= 1'b0;
            QE_B    <= 1'b0;
            QE_I    <= 1'b0;
        end else begin
            if (fire) begin
                phase   <= phase_nxt;
                rev_cnt <= rev_nxt;
                QE_A    <= phase_nxt[1] ^ phase_nxt[0];
                QE_B    <= phase_nxt[1];
            end
            if (counts_per_rev == '0) QE_I <= 1'b0;
            else if (fire)            QE_I <= (rev_nxt == '0);
        end
    end

    // Signed position count; clear takes priority over a coincident edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              position <= '0;
        else if (clear_position) position <= '0;
        else if (fire)           position <= direction ? position - 1'b1 : position + 1'b1;
    end

    assign busy = (state == S_LOAD) || (state == S_WAIT) || (state == S_STEP);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_qe_sim_generator_multi.sv
// Bench for qe_sim_generator_multi. The reference model schedules edges
// from the run parameters (first edge at cycle P+2, then every P cycles,
// done one cycle after the last edge) and tracks phase/position/index
// with plain integer arithmetic.
module tb_qe_sim_generator_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        start;
    logic        mode;
    logic        direction;
    logic [15:0] phase_period;
    logic [15:0] burst_count;
    logic [11:0] counts_per_rev;
    logic        clear_position;
    logic        QE_A, QE_B, QE_I, busy, done;
    logic [15:0] position;

    int n_checks = 0;
    int n_fail   = 0;

    int          m_phase;
    int          m_rev;
    logic [15:0] m_pos;
    bit          m_i;

    always #5 clk = ~clk;

    qe_sim_generator_multi dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .start          (start),
        .mode           (mode),
        .direction      (direction),
        .phase_period   (phase_period),
        .burst_count    (burst_count),
        .counts_per_rev (counts_per_rev),
        .clear_position (clear_position),
        .QE_A           (QE_A),
        .QE_B           (QE_B),
        .QE_I           (QE_I),
        .busy           (busy),
        .done           (done),
        .position       (position)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx, input int c, input bit exp_busy, input bit exp_done);
        string t;
        t = $sformatf("%s@%0d", ctx, c);
        chk({t, ":A"},    32'(QE_A),     32'((m_phase == 1) || (m_phase == 2)));
        chk({t, ":B"},    32'(QE_B),     32'(m_phase >= 2));
        chk({t, ":I"},    32'(QE_I),     32'(m_i));
        chk({t, ":busy"}, 32'(busy),     32'(exp_busy));
        chk({t, ":done"}, 32'(done),     32'(exp_done));
        chk({t, ":pos"},  32'(position), 32'(m_pos));
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_rev   = 0;
        m_pos   = 16'd0;
        m_i     = 1'b0;
    endtask

    task automatic model_edge(input bit dir, input int cpr);
        if (!dir) begin
            m_phase = (m_phase + 1) % 4;
            m_pos   = m_pos + 16'd1;
        end else begin
            m_phase = (m_phase + 3) % 4;
            m_pos   = m_pos - 16'd1;
        end
        if (cpr == 0)
            m_rev = 0;
        else if (!dir)
            m_rev = (m_rev >= cpr - 1) ? 0 : m_rev + 1;
        else
            m_rev = (m_rev == 0 || m_rev >= cpr) ? cpr - 1 : m_rev - 1;
        m_i = (cpr != 0) && (m_rev == 0);
    endtask

    // One run from IDLE. Cycle 0 is the start cycle; every later cycle is
    // checked at the falling edge. Continuous runs end by dropping enable
    // at drop_c; bursts end one cycle after done.
    task automatic run(input int p, input int n, input bit burst, input bit dir0,
                       input int cpr, input int flip_k, input int clr_k,
                       input int drop_c, input bit poke, input string ctx);
        int  pe, k, next_e, done_c, limit;
        bit  dropped, flipped, eb, ed;
        pe     = (p == 0) ? 1 : p;
        done_c = (n == 0) ? 2 : (pe + 2 + (n - 1) * pe + 1);
        limit  = burst ? done_c + 1 : drop_c + 3;
        mode           = burst;
        phase_period   = 16'(p);
        burst_count    = 16'(n);
        counts_per_rev = 12'(cpr);
        direction      = dir0;
        enable         = 1'b1;
        clear_position = 1'b0;
        start          = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (cpr == 0) m_i = 1'b0;
        k       = 0;
        next_e  = pe + 2;
        flipped = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            if (c > 1) begin
                @(posedge clk);
                @(negedge clk);
            end
            start   = 1'b0;
            dropped = (drop_c > 0) && (c > drop_c);
            if (!dropped && c == next_e && !(burst && k >= n)) begin
                model_edge(direction, cpr);
                k++;
                next_e += pe;
            end
            if (clear_position) m_pos = 16'd0;
            eb = !dropped && (burst ? (c < done_c) : 1'b1);
            ed = !dropped && burst && (c == done_c);
            check_all(ctx, c, eb, ed);
            clear_position = (clr_k >= 0) && (k == clr_k) && (next_e == c + 1) && !dropped;
            if (flip_k >= 0 && !flipped && k == flip_k) begin
                direction = ~direction;
                flipped   = 1'b1;
            end
            if (poke && c == 3) start = 1'b1;
            if (c == drop_c) enable = 1'b0;
        end
        clear_position = 1'b0;
        start          = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        enable         = 1'b0;
        start          = 1'b0;
        mode           = 1'b0;
        direction      = 1'b0;
        phase_period   = 16'd0;
        burst_count    = 16'd0;
        counts_per_rev = 12'd0;
        clear_position = 1'b0;
        model_reset();

        // reset state
        repeat (2) @(negedge clk);
        check_all("reset", 0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_all("post_reset", 0, 1'b0, 1'b0);

        // forward burst P=4, 8 edges, no index
        run(4, 8, 1'b1, 1'b0, 0, -1, -1, 0, 1'b1, "fwd_burst");
        chk("fwd_burst_final_pos", 32'(position), 32'd8);

        // reset in the middle of a burst, then a normal run
        mode = 1'b1; phase_period = 16'd3; burst_count = 16'd6;
        direction = 1'b0; enable = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check_all("mid_reset_async", 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_all("mid_reset_held", 0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        run(2, 3, 1'b1, 1'b0, 0, -1, -1, 0, 1'b0, "after_reset");

        // reverse continuous P=1, index every 4 edges, through zero
        run(1, 0, 1'b0, 1'b1, 4, -1, -1, 12, 1'b1, "rev_cont");

        // boundaries: empty burst, zero period, clear on an edge
        run(3, 0, 1'b1, 1'b0, 0, -1, -1, 0, 1'b0, "burst0");
        run(0, 4, 1'b1, 1'b0, 3, -1, -1, 0, 1'b0, "period0");
        run(3, 0, 1'b0, 1'b0, 0, -1, 2, 15, 1'b0, "clear_edge");

        // live reversal after 3 forward edges, abort, then restart
        model_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run(2, 0, 1'b0, 1'b0, 5, 3, -1, 14, 1'b0, "flip");
        run(1, 3, 1'b1, 1'b0, 5, -1, -1, 0, 1'b0, "restart");

        // randomized bursts and aborted continuous runs
        for (int r = 0; r < 8; r++) begin
            int  rp, rn, rc;
            bit  rb, rd;
            rp = int'($urandom_range(0, 4));
            rn = int'($urandom_range(0, 6));
            rc = int'($urandom_range(0, 5));
            rb = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            run(rp, rn, rb, rd, rc, -1, -1, rb ? 0 : int'($urandom_range(4, 20)),
                1'b0, $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
